// File: rtl/worker_relay.sv
// worker_relay: turns a synchronized sentinel flash edge into a delayed, fixed-width
// worker flash, then ignores further sentinel edges for a refractory period.
module worker_relay #(
  parameter int DELAY     = 200,
  parameter int FLASH_LEN = 15000,
  parameter int REFRACT   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       f1,
  output logic       f2,
  output logic       busy,
  output logic       miss,
  output logic [7:0] flash_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_FLASH, S_REFRACT} state_t;

  localparam logic [15:0] C_DELAY_LAST   = 16'(DELAY - 1);
  localparam logic [15:0] C_FLASH_LAST   = 16'(FLASH_LEN - 1);
  localparam logic [15:0] C_REFRACT_LAST = 16'(REFRACT - 1);

  logic        r_s1, r_s2, r_s3;
  logic        w_rise;
  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic        r_f2, r_busy, r_miss;
  logic [7:0]  r_flash_cnt;
  logic        w_f2_next, w_busy_next, w_miss_next;
  logic [7:0]  w_flash_cnt_next;

  // s1/s2 resolve metastability; s3 only delays s2 for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= f1;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_f2        <= 1'b0;
      r_busy      <= 1'b0;
      r_miss      <= 1'b0;
      r_flash_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_f2        <= w_f2_next;
      r_busy      <= w_busy_next;
      r_miss      <= w_miss_next;
      r_flash_cnt <= w_flash_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt + 16'd1;
    w_flash_cnt_next = r_flash_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 16'd0;
        if (w_rise) w_state_next = S_DELAY;
      end
      S_DELAY: begin
        if (r_cnt == C_DELAY_LAST) begin
          w_state_next     = S_FLASH;
          w_cnt_next       = 16'd0;
          w_flash_cnt_next = r_flash_cnt + 8'd1;
        end
      end
      S_FLASH: begin
        if (r_cnt == C_FLASH_LAST) begin
          w_state_next = S_REFRACT;
          w_cnt_next   = 16'd0;
        end
      end
      S_REFRACT: begin
        if (r_cnt == C_REFRACT_LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 16'd0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 16'd0;
      end
    endcase
    // Outputs are registered copies decoded from the next state
    w_f2_next   = (w_state_next == S_FLASH);
    w_busy_next = (w_state_next != S_IDLE);
    w_miss_next = w_rise && (r_state != S_IDLE);
  end

  assign f2        = r_f2;
  assign busy      = r_busy;
  assign miss      = r_miss;
  assign flash_cnt = r_flash_cnt;

endmodule

// File: tb/tb_worker_relay.sv
// tb_worker_relay: random and directed f1 stimulus; a timeline reference model
// predicts flash starts and miss pulses, and a monitor checks them as they appear.
module tb_worker_relay;
  localparam int D  = 4;
  localparam int FL = 8;
  localparam int RF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f1  = 1'b0;
  logic       f2, busy, miss;
  logic [7:0] flash_cnt;

  worker_relay #(.DELAY(D), .FLASH_LEN(FL), .REFRACT(RF)) dut (
    .clk      (clk),
    .rst      (rst),
    .f1       (f1),
    .f2       (f2),
    .busy     (busy),
    .miss     (miss),
    .flash_cnt(flash_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  // Expected events: flash start edge + flash count, and miss edges
  int exp_flash_edge[$];
  int exp_flash_cnt[$];
  int exp_miss_edge[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: a sentinel edge sampled at edge k is acted on at edge a=k+2.
  // Accepted only if the relay is idle by then; otherwise it is a miss at edge a.
  int prev_f1   = 0;
  int free_edge = 0;
  int model_cnt = 0;
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      prev_f1   = 0;
      free_edge = 0;
      model_cnt = 0;
      exp_flash_edge.delete();
      exp_flash_cnt.delete();
      exp_miss_edge.delete();
    end else begin
      if (f1 && prev_f1 == 0) begin
        int a;
        a = edge_n + 2;
        if (a >= free_edge) begin
          model_cnt = (model_cnt + 1) % 256;
          exp_flash_edge.push_back(a + D);
          exp_flash_cnt.push_back(model_cnt);
          free_edge = a + D + FL + RF + 1;
        end else begin
          exp_miss_edge.push_back(a);
        end
      end
      prev_f1 = f1 ? 1 : 0;
    end
  end

  // Monitor: samples DUT outputs on the falling edge
  int f2_prev = 0, busy_prev = 0, f2_run = 0, busy_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      f2_prev = 0; busy_prev = 0; f2_run = 0; busy_run = 0;
    end else begin
      if (f2 && f2_prev == 0) begin
        if (exp_flash_edge.size() == 0) begin
          check("unexpected_flash", 1, 0);
        end else begin
          int e, c;
          e = exp_flash_edge.pop_front();
          c = exp_flash_cnt.pop_front();
          $display("flash start edge %0d flash_cnt %0d", edge_n, flash_cnt);
          check("flash_edge", edge_n, e);
          check("flash_cnt", int'(flash_cnt), c);
        end
      end
      if (f2) begin
        f2_run++;
        check("f2_implies_busy", int'(busy), 1);
      end else if (f2_prev != 0) begin
        check("f2_width", f2_run, FL);
        f2_run = 0;
      end
      if (busy) busy_run++;
      else if (busy_prev != 0) begin
        check("busy_width", busy_run, D + FL + RF);
        busy_run = 0;
      end
      if (miss) begin
        $display("miss edge %0d", edge_n);
        if (exp_miss_edge.size() == 0) check("unexpected_miss", 1, 0);
        else check("miss_edge", edge_n, exp_miss_edge.pop_front());
      end
      f2_prev   = f2 ? 1 : 0;
      busy_prev = busy ? 1 : 0;
    end
  end

  task automatic drive(input logic v, input int n);
    f1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_f2", int'(f2), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_flash_cnt", int'(flash_cnt), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single 20-clock pulse
    drive(1'b1, 20); drive(1'b0, 30);
    check("phase_single_cnt", int'(flash_cnt), model_cnt);

    // Second edge 5 clocks after f2 rises -> miss
    drive(1'b1, 2); drive(1'b0, 9); drive(1'b1, 2); drive(1'b0, 40);
    check("phase_miss_cnt", int'(flash_cnt), model_cnt);

    // f1 held high for 100 clocks
    drive(1'b1, 100); drive(1'b0, 30);
    check("phase_hold_cnt", int'(flash_cnt), model_cnt);

    // Reset 3 clocks into FLASH
    drive(1'b1, 1); drive(1'b0, 8);
    #2 rst = 1'b1;
    #1;
    check("midflash_rst_f2", int'(f2), 0);
    check("midflash_rst_busy", int'(busy), 0);
    check("midflash_rst_flash_cnt", int'(flash_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1'b0, 40);

    // f1 already high when reset releases -> one flash
    @(negedge clk);
    #2 rst = 1'b1;
    f1 = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 30); drive(1'b0, 30);
    check("phase_release_cnt", int'(flash_cnt), model_cnt);

    // 256 well-spaced pulses from a clean count -> wraps to 0
    pulse_reset();
    drive(1'b0, 5);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, $urandom_range(1, 4));
      drive(1'b0, $urandom_range(20, 26));
    end
    check("wrap_model", model_cnt, 0);
    check("wrap_flash_cnt", int'(flash_cnt), 0);

    // Clock-aligned 1-clock glitch, then a sub-clock glitch that is never sampled
    drive(1'b1, 1); drive(1'b0, 30);
    #2 f1 = 1'b1;
    #2 f1 = 1'b0;
    @(negedge clk);
    drive(1'b0, 30);
    check("phase_glitch_cnt", int'(flash_cnt), model_cnt);

    // Dense random traffic exercising misses and refractory boundaries
    for (int i = 0; i < 80; i++) begin
      drive(1'b1, $urandom_range(1, 6));
      drive(1'b0, $urandom_range(1, 20));
    end

    for (int i = 0; i < 300 && (exp_flash_edge.size() > 0 || exp_miss_edge.size() > 0 || busy); i++)
      @(negedge clk);
    drive(1'b0, 3);
    check("pending_flash", exp_flash_edge.size(), 0);
    check("pending_miss", exp_miss_edge.size(), 0);
    check("final_flash_cnt", int'(flash_cnt), model_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
